// File: rtl/md_pkg.sv
// Shared encodings and default latencies for the multiply/divide HI/LO unit.
// MD_MADD_EN enables the MADD(U)/MSUB(U) accumulate ops.
package md_pkg;

  localparam logic [3:0] MD_OP_MULTU = 4'd0;
  localparam logic [3:0] MD_OP_MULT  = 4'd1;
  localparam logic [3:0] MD_OP_DIVU  = 4'd2;
  localparam logic [3:0] MD_OP_DIV   = 4'd3;
  localparam logic [3:0] MD_OP_MADDU = 4'd4;
  localparam logic [3:0] MD_OP_MADD  = 4'd5;
  localparam logic [3:0] MD_OP_MSUBU = 4'd6;
  localparam logic [3:0] MD_OP_MSUB  = 4'd7;
  localparam logic [3:0] MD_OP_NONE  = 4'd8;

  localparam logic [1:0] MD_MT_LO   = 2'b00;
  localparam logic [1:0] MD_MT_HI   = 2'b01;
  localparam logic [1:0] MD_MT_NONE = 2'b10;

  localparam logic [1:0] MD_MF_LO   = 2'b01;
  localparam logic [1:0] MD_MF_HI   = 2'b10;
  localparam logic [1:0] MD_MF_NONE = 2'b00;

  localparam int unsigned MD_MUL_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF = 10;

  typedef enum logic {
    StIdle,
    StRun
  } md_state_e;

  // Ops that start the unit; accumulate ops only exist when MD_MADD_EN is set.
  function automatic logic md_op_valid(logic [3:0] op);
`ifdef MD_MADD_EN
    return op <= MD_OP_MSUB;
`else
    return op <= MD_OP_DIV;
`endif
  endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational 64-bit {HI,LO} result for multiply, divide and (MD_MADD_EN) accumulate ops.
module md_compute
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MD_MADD_EN
  input  logic [63:0] hilo,
`endif
  output logic [63:0] result
);

  logic        signed_op;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] a_mag, b_mag, div_den, uq, ur, q, r;

  always_comb begin
    // Odd encodings are the signed variants across all op classes.
    signed_op = op[0];
    a_ext = signed_op ? {{32{a[31]}}, a} : {32'b0, a};
    b_ext = signed_op ? {{32{b[31]}}, b} : {32'b0, b};
    prod  = a_ext * b_ext;

    a_mag   = (signed_op && a[31]) ? -a : a;
    b_mag   = (signed_op && b[31]) ? -b : b;
    div_den = (b_mag == 32'd0) ? 32'd1 : b_mag;
    uq      = a_mag / div_den;
    ur      = a_mag % div_den;
    q       = (signed_op && (a[31] ^ b[31])) ? -uq : uq;
    r       = (signed_op && a[31]) ? -ur : ur;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (signed_op && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end

    result = 64'd0;
    case (op)
      MD_OP_MULTU, MD_OP_MULT: result = prod;
      MD_OP_DIVU, MD_OP_DIV:   result = {r, q};
`ifdef MD_MADD_EN
      MD_OP_MADDU, MD_OP_MADD: result = hilo + prod;
      MD_OP_MSUBU, MD_OP_MSUB: result = hilo - prod;
`endif
      default:                 result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_hilo_unit.sv
// EX-stage multi-cycle multiply/divide unit holding the HI/LO registers.
// MD_MADD_EN enables MADD(U)/MSUB(U) (ops 4-7); otherwise they are treated as no-ops.
module md_hilo_unit
  import md_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MD_MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [3:0]  mul_op,
  input  logic [1:0]  mt_hilo,
  input  logic [1:0]  mf_hilo,
  input  logic        flush,
  output logic        start,
  output logic        busy,
  output logic [31:0] hilo_out
);

  localparam logic [3:0] MulLoad = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DivLoad = 4'(DIV_CYCLES - 1);

  md_state_e   state_q;
  logic [3:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [63:0] pending_q, result;
  logic        is_div;

  md_compute u_compute (
    .op     (mul_op),
    .a      (src_a),
    .b      (src_b),
`ifdef MD_MADD_EN
    .hilo   ({hi_q, lo_q}),
`endif
    .result (result)
  );

  assign is_div = (mul_op == MD_OP_DIVU) || (mul_op == MD_OP_DIV);
  assign busy   = (state_q == StRun);
  assign start  = md_op_valid(mul_op) && !flush && !busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pending_q <= 64'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            pending_q <= result;
            cnt_q     <= is_div ? DivLoad : MulLoad;
            state_q   <= StRun;
          end else if (!flush && mt_hilo == MD_MT_LO) begin
            lo_q <= src_a;
          end else if (!flush && mt_hilo == MD_MT_HI) begin
            hi_q <= src_a;
          end
        end
        StRun: begin
          // Flush and MT are ignored here: the issued op is already committed.
          if (cnt_q == 4'd0) begin
            {hi_q, lo_q} <= pending_q;
            state_q      <= StIdle;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    hilo_out = 32'd0;
    case (mf_hilo)
      MD_MF_LO: hilo_out = lo_q;
      MD_MF_HI: hilo_out = hi_q;
      default:  hilo_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_md_hilo_unit.sv
// Directed self-checking bench for md_hilo_unit with hand-computed HI/LO results.
module tb_md_hilo_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] src_a, src_b;
  logic [3:0]  mul_op;
  logic [1:0]  mt_hilo, mf_hilo;
  logic        flush;
  logic        start, busy;
  logic [31:0] hilo_out;

  int n_total = 0;
  int n_pass  = 0;

  md_hilo_unit #(
    .MUL_CYCLES (5),
    .DIV_CYCLES (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .src_a    (src_a),
    .src_b    (src_b),
    .mul_op   (mul_op),
    .mt_hilo  (mt_hilo),
    .mf_hilo  (mf_hilo),
    .flush    (flush),
    .start    (start),
    .busy     (busy),
    .hilo_out (hilo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    mf_hilo = MD_MF_HI;
    #1 hi = hilo_out;
    mf_hilo = MD_MF_LO;
    #1 lo = hilo_out;
    mf_hilo = MD_MF_NONE;
  endtask

  // Issue one op; returns the start seen in the issue cycle.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic st);
    mul_op = op;
    src_a  = a;
    src_b  = b;
    #1 st = start;
    step();
    mul_op = MD_OP_NONE;
  endtask

  // Counts cycles with busy high after the issue edge, bounded at 40.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
  endtask

  task automatic mt_write(input logic [1:0] sel, input logic [31:0] v);
    mt_hilo = sel;
    src_a   = v;
    step();
    mt_hilo = MD_MT_NONE;
  endtask

  logic [31:0] hi, lo;
  logic        st;
  int          n;

  initial begin
    reset   = 1'b1;
    src_a   = 32'd0;
    src_b   = 32'd0;
    mul_op  = MD_OP_NONE;
    mt_hilo = MD_MT_NONE;
    mf_hilo = MD_MF_NONE;
    flush   = 1'b0;
    step();
    step();
    reset = 1'b0;

    check("rst_busy", 64'(busy), 64'd0);
    check("rst_start", 64'(start), 64'd0);
    read_hilo(hi, lo);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("mf_none", 64'(hilo_out), 64'd0);

    // MULT -3 * 7 = -21
    issue(MD_OP_MULT, 32'hFFFF_FFFD, 32'd7, st);
    check("mult_start", 64'(st), 64'd1);
    read_hilo(hi, lo);
    check("mult_old_hilo", {hi, lo}, 64'd0);
    count_busy(n);
    check("mult_cycles", 64'(n), 64'd5);
    read_hilo(hi, lo);
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    issue(MD_OP_DIVU, 32'd100, 32'd7, st);
    check("divu_start", 64'(st), 64'd1);
    count_busy(n);
    check("divu_cycles", 64'(n), 64'd10);
    read_hilo(hi, lo);
    check("divu_hilo", {hi, lo}, {32'd2, 32'd14});

    issue(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, st);
    count_busy(n);
    read_hilo(hi, lo);
    check("div_neg", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    issue(MD_OP_DIV, 32'd5, 32'd0, st);
    count_busy(n);
    read_hilo(hi, lo);
    check("div_zero", {hi, lo}, {32'd5, 32'hFFFF_FFFF});

    issue(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, st);
    count_busy(n);
    read_hilo(hi, lo);
    check("div_ovf", {hi, lo}, {32'd0, 32'h8000_0000});

    issue(MD_OP_MULTU, 32'hFFFF_FFFF, 32'd2, st);
    count_busy(n);
    read_hilo(hi, lo);
    check("multu", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

    mt_write(MD_MT_HI, 32'd1);
    mt_write(MD_MT_LO, 32'd2);
    read_hilo(hi, lo);
    check("mt_hilo", {hi, lo}, {32'd1, 32'd2});

    issue(MD_OP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st);
    count_busy(n);
    read_hilo(hi, lo);
`ifdef MD_MADD_EN
    check("maddu_start", 64'(st), 64'd1);
    check("maddu_cycles", 64'(n), 64'd5);
    check("maddu_hilo", {hi, lo}, 64'hFFFF_FFFF_0000_0003);
`else
    check("maddu_start", 64'(st), 64'd0);
    check("maddu_cycles", 64'(n), 64'd0);
    check("maddu_hilo", {hi, lo}, {32'd1, 32'd2});
`endif

    mt_write(MD_MT_HI, 32'h1111_1111);
    mt_write(MD_MT_LO, 32'h2222_2222);
    flush = 1'b1;
    issue(MD_OP_MULT, 32'd3, 32'd4, st);
    check("flush_start", 64'(st), 64'd0);
    check("flush_busy", 64'(busy), 64'd0);
    mt_write(MD_MT_LO, 32'hDEAD_BEEF);
    flush = 1'b0;
    read_hilo(hi, lo);
    check("flush_hilo", {hi, lo}, {32'h1111_1111, 32'h2222_2222});

    mt_write(MD_MT_LO, 32'hA5);
    issue(MD_OP_DIV, 32'd100, 32'd7, st);
    check("rdiv_busy1", 64'(busy), 64'd1);
    step();
    mt_hilo = MD_MT_LO;
    src_a   = 32'h55;
    step();
    mt_hilo = MD_MT_NONE;
    check("rdiv_busy3", 64'(busy), 64'd1);
    read_hilo(hi, lo);
    check("mt_while_busy", {hi, lo}, {32'h1111_1111, 32'hA5});
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rdiv_busy_after", 64'(busy), 64'd0);
    read_hilo(hi, lo);
    check("rdiv_hilo", {hi, lo}, 64'd0);
    step();
    step();
    check("rdiv_stays_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/md_hilo_unit.md
Name: md_hilo_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, placed in the EX stage directly downstream of the instruction decoder.
- Consumes the decoder's MulOp, MTHILO and MFHILO fields plus the rs/rt operands.
- Executes MULT/MULTU/DIV/DIVU/MADD(U)/MSUB(U) over a fixed latency, services MTHI/MTLO writes, and returns HI/LO for MFHI/MFLO.
- Provides start/busy so the hazard unit can stall dependent HI/LO instructions.

Parameters:
- MUL_CYCLES, 5, busy cycles for multiply-class ops (1..15).
- DIV_CYCLES, 10, busy cycles for divide ops (1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- src_a  in  32  rs operand (forwarded value).
- src_b  in  32  rt operand (forwarded value).
- mul_op  in  4  0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MADDU, 5 MADD, 6 MSUBU, 7 MSUB, 8 none; 9-15 treated as none.
- mt_hilo  in  2  00 MTLO, 01 MTHI, 10/11 none.
- mf_hilo  in  2  01 read LO, 10 read HI, 00/11 read 0.
- flush  in  1  the EX instruction is cancelled (exception/ERET downstream); suppresses start and MT writes this cycle.
- start  out  1  combinational: valid mul_op issued this cycle and not flushed and not busy.
- busy  out  1  registered: operation in flight.
- hilo_out  out  32  combinational read selected by mf_hilo.

Behaviour:
- Reset: HI=0, LO=0, busy=0, counter=0, pending result=0. start and hilo_out then follow their inputs combinationally.
- States: IDLE, RUN.
- IDLE -> RUN on start. At that edge:
  - operands are latched;
  - the 64-bit result is computed from the latched values into a pending register;
  - counter is loaded with MUL_CYCLES-1 (ops 0,1,4-7) or DIV_CYCLES-1 (ops 2,3);
  - busy=1 from the next cycle.
- RUN: counter decrements each cycle. When counter==0, at that edge {HI,LO} ← pending, busy←0, state←IDLE.
- busy is high for exactly MUL_CYCLES / DIV_CYCLES cycles. New HI/LO are visible on hilo_out on the first cycle busy=0.
- start while busy is impossible by definition: mul_op is ignored when busy, and the hazard unit must stall.
- Arithmetic:
  - MULT: signed 32x32->64. MULTU: unsigned. HI=upper 32 bits, LO=lower 32 bits.
  - DIV/DIVU: LO=quotient, HI=remainder. The remainder takes the sign of the dividend (truncating division).
  - Divide by zero: LO=32'hFFFF_FFFF, HI=src_a. No trap.
  - DIV overflow (0x80000000 / -1): LO=0x80000000, HI=0.
  - MADD(U)/MSUB(U): {HI,LO} ± product, using the HI/LO value at issue. Wraps modulo 2^64.
- MTHI/MTLO: write src_a into HI/LO at the edge when not busy and not flush. Ignored while busy.
- MT in the same cycle as start: impossible, since one instruction carries one field. If both are nonzero, start has priority and the MT is dropped.
- flush:
  - With start: nothing issues.
  - During RUN: no effect; the in-flight op completes (issue is architecturally committed).
- hilo_out during busy returns the old HI/LO; the hazard unit stalls MF instructions on start|busy.
- reset mid-RUN aborts the op; HI/LO=0.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined: ops 4-7 execute as specified above.
- Undefined: ops 4-7 are treated as none. start stays 0, and there is no accumulator adder or extra operand path.

Decomposition:
- Shared package md_pkg holds:
  - mul_op encodings (MD_OP_MULTU..MD_OP_MSUB, MD_OP_NONE=8);
  - MTHILO/MFHILO encodings;
  - the default latency constants.
- Sub-module md_compute: purely combinational 64-bit result from op, a, b, {HI,LO}, containing the multiply, divide, div-by-zero/overflow handling and accumulate logic.
- md_hilo_unit keeps the FSM, counter and registers.

Test Plan:
- MULT a=-3, b=7 -> start=1, busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB; mf_hilo=01 reads 0xFFFFFFEB.
- DIVU a=100, b=7 -> busy 10 cycles, LO=14, HI=2. DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV a=5, b=0 -> LO=0xFFFFFFFF, HI=5. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x1, MTLO 0x2, then MADDU a=b=0xFFFFFFFF -> {HI,LO}=0x1_00000002+0xFFFFFFFE_00000001=0xFFFFFFFF_00000003. Without MD_MADD_EN: start=0, HI/LO unchanged.
- MULT with flush=1 -> start=0, busy stays 0, HI/LO unchanged. MTLO with flush=1 -> LO unchanged.
- reset asserted on the 3rd busy cycle of DIV -> next cycle busy=0, HI=LO=0. MTLO issued during busy -> ignored.
